// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolver: S1 captures/decodes, S2 resolves, commits SPRs and redirects PC; commit visible 2 cycles after valid_i.
// No backpressure path: stall_i freezes every stage and SPR (valid_i ignored while stalled); a taken commit kills the S1 instruction.
module branch_resolve_unit #(
    parameter int                    ADDR_WIDTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter bit                    HAS_TAR      = 1'b1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  stall_i,
    input  logic                  valid_i,
    input  logic [2:0]            kind_i,
    input  logic                  AA_i,
    input  logic                  LK_i,
    input  logic [4:0]            BO_i,
    input  logic [4:0]            BI_i,
    input  logic [23:0]           imm_i,
    input  logic [ADDR_WIDTH-1:0] instructionAddress_i,
    input  logic [31:0]           condReg_i,
    input  logic                  is64Bit_i,
    input  logic                  sprWrEn_i,
    input  logic [1:0]            sprSel_i,
    input  logic [ADDR_WIDTH-1:0] sprData_i,
    output logic                  valid_o,
    output logic                  isBranching_o,
    output logic [ADDR_WIDTH-1:0] branchInstructionAddress_o,
    output logic [ADDR_WIDTH-1:0] PC_o,
    output logic [ADDR_WIDTH-1:0] linkReg_o,
    output logic [ADDR_WIDTH-1:0] countReg_o,
    output logic [ADDR_WIDTH-1:0] targetAddrReg_o
);

    localparam logic [2:0] KIND_B     = 3'd0;
    localparam logic [2:0] KIND_BC    = 3'd1;
    localparam logic [2:0] KIND_BCLR  = 3'd2;
    localparam logic [2:0] KIND_BCCTR = 3'd3;
    localparam logic [2:0] KIND_BCTAR = 3'd4;

    localparam logic [1:0] SPR_LR  = 2'd0;
    localparam logic [1:0] SPR_CTR = 2'd1;
    localparam logic [1:0] SPR_TAR = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LOW32_MASK = ADDR_WIDTH'({32{1'b1}});
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    // BO fields use IBM bit numbering: BO[0] is BO_i[4]
    typedef struct packed {
        logic                  is_b;
        logic                  is_bc;
        logic                  is_bclr;
        logic                  is_bcctr;
        logic                  is_bctar;
        logic                  aa;
        logic                  lk;
        logic                  bo_ign_cond;
        logic                  bo_cond_val;
        logic                  bo_ign_ctr;
        logic                  bo_ctr_zero;
        logic                  cr_bit;
        logic [ADDR_WIDTH-1:0] rel_off;
        logic [ADDR_WIDTH-1:0] cia;
        logic                  is64;
    } s1_t;

    s1_t                   s1_d;
    s1_t                   s1_q;
    logic                  s1_vld_q;

    logic                  valid_q;
    logic                  br_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] bia_q;
    logic [ADDR_WIDTH-1:0] lr_q;
    logic [ADDR_WIDTH-1:0] ctr_q;
    logic [ADDR_WIDTH-1:0] tar_q;

    logic [ADDR_WIDTH-1:0] li_off;
    logic [ADDR_WIDTH-1:0] bd_off;
    logic                  bo_hint_unused;

    logic                  kind_ok;
    logic [ADDR_WIDTH-1:0] ctr_dec;
    logic                  ctr_nz;
    logic                  ctr_ok;
    logic                  cond_ok;
    logic                  taken;
    logic                  dec_ctr;
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] rel_tgt;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [ADDR_WIDTH-1:0] link_val;

    logic [ADDR_WIDTH-1:0] lr_nxt;
    logic [ADDR_WIDTH-1:0] ctr_nxt;
    logic [ADDR_WIDTH-1:0] tar_nxt;

    function automatic logic [ADDR_WIDTH-1:0] mode_mask(input logic [ADDR_WIDTH-1:0] v,
                                                        input logic is64);
        return is64 ? v : (v & LOW32_MASK);
    endfunction

    // ---------------- S1 decode ----------------
    assign bo_hint_unused = BO_i[0];
    assign li_off = {{(ADDR_WIDTH-26){imm_i[23]}}, imm_i, 2'b00};
    assign bd_off = {{(ADDR_WIDTH-16){imm_i[13]}}, imm_i[13:0], 2'b00};

    always_comb begin
        s1_d             = '0;
        s1_d.is_b        = (kind_i == KIND_B);
        s1_d.is_bc       = (kind_i == KIND_BC);
        s1_d.is_bclr     = (kind_i == KIND_BCLR);
        s1_d.is_bcctr    = (kind_i == KIND_BCCTR);
        s1_d.is_bctar    = (kind_i == KIND_BCTAR) && HAS_TAR;
        s1_d.aa          = AA_i;
        s1_d.lk          = LK_i;
        s1_d.bo_ign_cond = BO_i[4];
        s1_d.bo_cond_val = BO_i[3];
        s1_d.bo_ign_ctr  = BO_i[2];
        s1_d.bo_ctr_zero = BO_i[1];
        // CR bit 32+BI lives at index 31-BI, which is ~BI for a 5-bit BI
        s1_d.cr_bit      = condReg_i[~BI_i];
        s1_d.rel_off     = (kind_i == KIND_B) ? li_off : bd_off;
        s1_d.cia         = instructionAddress_i;
        s1_d.is64        = is64Bit_i;
    end

    // ---------------- S2 resolve ----------------
    always_comb begin
        kind_ok  = s1_q.is_b | s1_q.is_bc | s1_q.is_bclr | s1_q.is_bcctr | s1_q.is_bctar;
        ctr_dec  = ctr_q - ADDR_WIDTH'(1);
        ctr_nz   = mode_mask(ctr_dec, s1_q.is64) != '0;
        ctr_ok   = s1_q.bo_ign_ctr | (ctr_nz ^ s1_q.bo_ctr_zero);
        cond_ok  = s1_q.bo_ign_cond | (s1_q.cr_bit == s1_q.bo_cond_val);
        taken    = s1_q.is_b | (kind_ok & ctr_ok & cond_ok);
        dec_ctr  = (s1_q.is_bc | s1_q.is_bclr) & ~s1_q.bo_ign_ctr;
        seq_pc   = s1_q.cia + ADDR_WIDTH'(4);
        rel_tgt  = s1_q.aa ? s1_q.rel_off : (s1_q.cia + s1_q.rel_off);

        target = rel_tgt;
        if (s1_q.is_bclr) begin
            target = lr_q & ALIGN_MASK;
        end else if (s1_q.is_bcctr) begin
            target = ctr_q & ALIGN_MASK;
        end else if (s1_q.is_bctar) begin
            target = tar_q & ALIGN_MASK;
        end

        next_pc  = mode_mask(taken ? target : seq_pc, s1_q.is64);
        link_val = mode_mask(seq_pc, s1_q.is64);
    end

    // SPR write port first, so a simultaneous branch commit overrides it
    always_comb begin
        lr_nxt  = lr_q;
        ctr_nxt = ctr_q;
        tar_nxt = tar_q;
        if (sprWrEn_i) begin
            unique case (sprSel_i)
                SPR_LR:  lr_nxt  = sprData_i;
                SPR_CTR: ctr_nxt = sprData_i;
                SPR_TAR: if (HAS_TAR) tar_nxt = sprData_i;
                default: ;
            endcase
        end
        if (s1_vld_q && kind_ok && s1_q.lk) begin
            lr_nxt = link_val;
        end
        if (s1_vld_q && dec_ctr) begin
            ctr_nxt = ctr_dec;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            valid_q  <= 1'b0;
            br_q     <= 1'b0;
            pc_q     <= RESET_VECTOR;
            bia_q    <= '0;
            lr_q     <= '0;
            ctr_q    <= '0;
            tar_q    <= '0;
        end else if (!stall_i) begin
            s1_vld_q <= valid_i & ~(s1_vld_q & taken);
            if (valid_i) begin
                s1_q <= s1_d;
            end
            valid_q <= s1_vld_q;
            br_q    <= s1_vld_q & taken;
            if (s1_vld_q) begin
                pc_q  <= next_pc;
                bia_q <= s1_q.cia;
            end
            lr_q  <= lr_nxt;
            ctr_q <= ctr_nxt;
            tar_q <= tar_nxt;
        end
    end

    // The commit pulse stays pending across a stall and shows in the first unstalled cycle
    assign valid_o                    = valid_q & ~stall_i;
    assign isBranching_o              = br_q & ~stall_i;
    assign branchInstructionAddress_o = bia_q;
    assign PC_o                       = pc_q;
    assign linkReg_o                  = lr_q;
    assign countReg_o                 = ctr_q;
    assign targetAddrReg_o            = tar_q;

endmodule
